win3x3_line_sched: RTL



---
 rtl/win3x3_line_sched_if.sv | 38 +++
 rtl/win3x3_line_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/win3x3_line_sched_if.sv
// Stream, line-buffer control and status bundle between the video source and the 3x3 sequencer.
// The slave modport is the sequencer side; the master modport is the source/datapath side.
interface win3x3_line_sched_if #(
    parameter int CNT_W = 12
);
    logic             in_vsync;
    logic             in_valid;
    logic [1:0]       cfg_mode_i;
    logic [1:0]       cfg_mode_o;
    logic             lb_clear;
    logic             lb0_wr_en;
    logic             lb0_rd_en;
    logic             lb1_rd_en;
    logic             out_valid;
    logic [CNT_W-1:0] out_col;
    logic [CNT_W-1:0] out_row;
    logic             edge_top;
    logic             edge_bottom;
    logic             edge_left;
    logic             edge_right;
    logic             frame_done;
    logic             err_len;
    logic             busy;

    modport master (
        output in_vsync, in_valid, cfg_mode_i,
        input  cfg_mode_o, lb_clear, lb0_wr_en, lb0_rd_en, lb1_rd_en, out_valid,
               out_col, out_row, edge_top, edge_bottom, edge_left, edge_right,
               frame_done, err_len, busy
    );

    modport slave (
        input  in_vsync, in_valid, cfg_mode_i,
        output cfg_mode_o, lb_clear, lb0_wr_en, lb0_rd_en, lb1_rd_en, out_valid,
               out_col, out_row, edge_top, edge_bottom, edge_left, edge_right,
               frame_done, err_len, busy
    );
endinterface

// File: rtl/win3x3_line_sched.sv
// Line-buffer sequencer for the 3x3 window: primes lb0/lb1, aligns reads to the live row, flushes the last row.
// All outputs registered, 1 cycle after the causing input; no backpressure, the source is free-running.
module win3x3_line_sched #(
    parameter int IMG_W   = 1280,
    parameter int IMG_H   = 720,
    parameter int H_BLANK = 370,
    parameter int CNT_W   = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    win3x3_line_sched_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] BLANK    = CNT_W'(H_BLANK);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_FLUSH} state_t;

    state_t           r_state, w_state;
    logic             r_vs_d;
    logic             w_vs_rise;
    logic [CNT_W-1:0] r_in_col, w_in_col;
    logic [CNT_W-1:0] r_in_line, w_in_line;
    logic [CNT_W-1:0] r_blank, w_blank;
    logic             r_done_pend, w_done_pend;
    logic [1:0]       r_mode, w_mode;
    logic             r_lb_clear, w_lb_clear;
    logic             r_lb0_wr, w_lb0_wr;
    logic             r_lb0_rd, w_lb0_rd;
    logic             r_lb1_rd, w_lb1_rd;
    logic             r_out_valid, w_out_valid;
    logic [CNT_W-1:0] r_out_col, w_out_col;
    logic [CNT_W-1:0] r_out_row, w_out_row;
    logic             r_edge_t, w_edge_t;
    logic             r_edge_b, w_edge_b;
    logic             r_edge_l, w_edge_l;
    logic             r_edge_r, w_edge_r;
    logic             r_frame_done, w_frame_done;
    logic             r_err_len, w_err_len;

    assign w_vs_rise = bus.in_vsync & ~r_vs_d;

    always_comb begin
        w_state      = r_state;
        w_in_col     = r_in_col;
        w_in_line    = r_in_line;
        w_blank      = r_blank;
        w_done_pend  = 1'b0;
        w_mode       = r_mode;
        w_lb_clear   = 1'b0;
        w_lb0_wr     = 1'b0;
        w_lb0_rd     = 1'b0;
        w_lb1_rd     = 1'b0;
        w_out_valid  = 1'b0;
        w_out_col    = '0;
        w_out_row    = '0;
        w_frame_done = 1'b0;
        w_err_len    = 1'b0;

        // A new frame overrides everything, including a pending frame_done.
        if (w_vs_rise) begin
            w_mode     = bus.cfg_mode_i;
            w_lb_clear = 1'b1;
            w_in_col   = '0;
            w_in_line  = '0;
            w_blank    = '0;
            w_state    = S_PRIME;
        end else begin
            w_frame_done = r_done_pend;
            case (r_state)
                S_PRIME, S_RUN: begin
                    if (bus.in_valid) begin
                        w_lb0_wr = 1'b1;
                        if (r_state == S_RUN) begin
                            w_lb0_rd    = 1'b1;
                            w_out_valid = 1'b1;
                            w_out_col   = r_in_col;
                            w_out_row   = r_in_line - CNT_W'(1);
                            w_lb1_rd    = (r_in_line > CNT_W'(1));
                        end
                        if (r_in_col == LAST_COL) begin
                            w_in_col = '0;
                            if (r_state == S_PRIME) begin
                                w_in_line = CNT_W'(1);
                                w_state   = S_RUN;
                            end else if (r_in_line == LAST_ROW) begin
                                w_blank = '0;
                                w_state = S_FLUSH;
                            end else begin
                                w_in_line = r_in_line + CNT_W'(1);
                            end
                        end else begin
                            w_in_col = r_in_col + CNT_W'(1);
                        end
                    end else if (r_in_col != '0) begin
                        // Short line: drop the frame and wait for the next vsync.
                        w_err_len  = 1'b1;
                        w_lb_clear = 1'b1;
                        w_in_col   = '0;
                        w_in_line  = '0;
                        w_state    = S_IDLE;
                    end
                end
                S_FLUSH: begin
                    w_err_len = bus.in_valid;
                    if (r_blank != BLANK) begin
                        w_blank = r_blank + CNT_W'(1);
                    end else begin
                        w_lb0_rd    = 1'b1;
                        w_lb1_rd    = 1'b1;
                        w_out_valid = 1'b1;
                        w_out_col   = r_in_col;
                        w_out_row   = LAST_ROW;
                        if (r_in_col == LAST_COL) begin
                            w_in_col    = '0;
                            w_done_pend = 1'b1;
                            w_state     = S_IDLE;
                        end else begin
                            w_in_col = r_in_col + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        w_edge_t = w_out_valid && (w_out_row == '0);
        w_edge_b = w_out_valid && (w_out_row == LAST_ROW);
        w_edge_l = w_out_valid && (w_out_col == '0);
        w_edge_r = w_out_valid && (w_out_col == LAST_COL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_vs_d       <= 1'b0;
            r_in_col     <= '0;
            r_in_line    <= '0;
            r_blank      <= '0;
            r_done_pend  <= 1'b0;
            r_mode       <= '0;
            r_lb_clear   <= 1'b0;
            r_lb0_wr     <= 1'b0;
            r_lb0_rd     <= 1'b0;
            r_lb1_rd     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_col    <= '0;
            r_out_row    <= '0;
            r_edge_t     <= 1'b0;
            r_edge_b     <= 1'b0;
            r_edge_l     <= 1'b0;
            r_edge_r     <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_len    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_vs_d       <= bus.in_vsync;
            r_in_col     <= w_in_col;
            r_in_line    <= w_in_line;
            r_blank      <= w_blank;
            r_done_pend  <= w_done_pend;
            r_mode       <= w_mode;
            r_lb_clear   <= w_lb_clear;
            r_lb0_wr     <= w_lb0_wr;
            r_lb0_rd     <= w_lb0_rd;
            r_lb1_rd     <= w_lb1_rd;
            r_out_valid  <= w_out_valid;
            r_out_col    <= w_out_col;
            r_out_row    <= w_out_row;
            r_edge_t     <= w_edge_t;
            r_edge_b     <= w_edge_b;
            r_edge_l     <= w_edge_l;
            r_edge_r     <= w_edge_r;
            r_frame_done <= w_frame_done;
            r_err_len    <= w_err_len;
        end
    end

    assign bus.cfg_mode_o  = r_mode;
    assign bus.lb_clear    = r_lb_clear;
    assign bus.lb0_wr_en   = r_lb0_wr;
    assign bus.lb0_rd_en   = r_lb0_rd;
    assign bus.lb1_rd_en   = r_lb1_rd;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_col     = r_out_col;
    assign bus.out_row     = r_out_row;
    assign bus.edge_top    = r_edge_t;
    assign bus.edge_bottom = r_edge_b;
    assign bus.edge_left   = r_edge_l;
    assign bus.edge_right  = r_edge_r;
    assign bus.frame_done  = r_frame_done;
    assign bus.err_len     = r_err_len;
    assign bus.busy        = (r_state != S_IDLE);
endmodule
